seq_detector_param: RTL and testbench

- Parametrised Moore serial-pattern detector; successor to the fixed 3-bit hand-built sequence FSM.
- Shifts in a 1-bit serial input `x` and compares the last PAT_W bits against a loadable pattern with per-bit don't-care mask.
- Supports overlapping and non-overlapping detection, chosen at run time.
- Counts matches in a saturating counter and reports a 2-bit state code on `y`.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_window.sv | 56 +++++
 rtl/seq_detector_param.sv | 86 ++++++++
 tb/tb_seq_detector_param.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared encodings and helpers for the parametrised serial-pattern detector.
package seq_det_pkg;

   localparam logic [1:0] Y_IDLE  = 2'b00;
   localparam logic [1:0] Y_FILL  = 2'b01;
   localparam logic [1:0] Y_ARMED = 2'b10;
   localparam logic [1:0] Y_HIT   = 2'b11;

   // Caller passes the all-ones value of its counter width as max_val.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
      return (val >= max_val) ? max_val : val + 32'd1;
   endfunction

endpackage

// File: rtl/seq_window.sv
// Shift window, fill tracker and masked compare; hit is the combinational
// match condition for the current edge.
module seq_window #(
   parameter int PAT_W = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic                           x,
   input  logic                           clear,
   input  logic                           overlap,
   input  logic [PAT_W-1:0]               pattern,
   input  logic [PAT_W-1:0]               mask,
   output logic [$clog2(PAT_W+1)-1:0]     fill,
   output logic                           hit
);

   localparam int FW = $clog2(PAT_W+1);
   localparam logic [FW-1:0] FULL = FW'(PAT_W);

   logic [PAT_W-1:0] window, window_next, shifted;
   logic [FW-1:0]    fill_next, fill_inc;

   assign shifted  = {window[PAT_W-2:0], x};
   assign fill_inc = (fill == FULL) ? fill : fill + FW'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         window <= '0;
         fill   <= '0;
      end else begin
         window <= window_next;
         fill   <= fill_next;
      end
   end

   // A load discards this edge's bit, so it must also veto the compare.
   always_comb begin
      hit = 1'b0;
      if (en && !clear && fill_inc == FULL && ((shifted ^ pattern) & mask) == '0)
         hit = 1'b1;
   end

   always_comb begin
      window_next = window;
      fill_next   = fill;
      if (clear) begin
         window_next = '0;
         fill_next   = '0;
      end else if (en) begin
         window_next = shifted;
         fill_next   = (hit && !overlap) ? '0 : fill_inc;
      end
   end

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector: loadable pattern/mask, match pulse,
// saturating match counter and 2-bit state code.
//
// state  | meaning
// IDLE   | fill == 0, no match pending
// FILL   | 0 < fill < PAT_W, window partially loaded
// ARMED  | fill == PAT_W, window full, last edge did not match
// HIT    | match flop set (wins over IDLE after a non-overlap match)
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int               PAT_W       = 4,
   parameter int               CNT_W       = 8,
   parameter logic [PAT_W-1:0] PAT_DEFAULT = 4'b1011
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             x,
   input  logic             overlap,
   input  logic             pat_ld,
   input  logic [PAT_W-1:0] pat_in,
   input  logic [PAT_W-1:0] mask_in,
   input  logic             clr_cnt,
   output logic [1:0]       y,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int FW = $clog2(PAT_W+1);
   localparam logic [FW-1:0]    FULL    = FW'(PAT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [PAT_W-1:0] pattern, mask;
   logic [FW-1:0]    fill;
   logic             hit;
   logic [CNT_W-1:0] cnt_next;

   seq_window #(.PAT_W(PAT_W)) u_window (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .x       (x),
      .clear   (pat_ld),
      .overlap (overlap),
      .pattern (pattern),
      .mask    (mask),
      .fill    (fill),
      .hit     (hit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pattern   <= PAT_DEFAULT;
         mask      <= '1;
         match     <= 1'b0;
         match_cnt <= '0;
      end else begin
         if (pat_ld) begin
            pattern <= pat_in;
            mask    <= mask_in;
         end
         match     <= hit;
         match_cnt <= cnt_next;
      end
   end

   always_comb begin
      cnt_next = match_cnt;
      if (clr_cnt)
         cnt_next = hit ? CNT_W'(1) : '0;
      else if (hit)
         cnt_next = CNT_W'(sat_inc(32'(match_cnt), 32'(CNT_MAX)));
   end

   always_comb begin
      y = Y_FILL;
      if (match)
         y = Y_HIT;
      else if (fill == '0)
         y = Y_IDLE;
      else if (fill == FULL)
         y = Y_ARMED;
   end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: vector table for detection/masking, hand sequences for
// reset, counter saturation/clear and load priority.
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0, x = 1'b0, overlap = 1'b0, pat_ld = 1'b0, clr_cnt = 1'b0;
   logic [3:0] pat_in = 4'b1011, mask_in = 4'b1111;
   logic [1:0] y, y_c;
   logic       match, match_c;
   logic [7:0] match_cnt;
   logic [1:0] match_cnt_c;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   seq_detector_param #(.PAT_W(4), .CNT_W(8), .PAT_DEFAULT(4'b1011)) dut (
      .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .pat_ld(pat_ld),
      .pat_in(pat_in), .mask_in(mask_in), .clr_cnt(clr_cnt),
      .y(y), .match(match), .match_cnt(match_cnt));

   seq_detector_param #(.PAT_W(4), .CNT_W(2), .PAT_DEFAULT(4'b1011)) dut_c (
      .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .pat_ld(pat_ld),
      .pat_in(pat_in), .mask_in(mask_in), .clr_cnt(clr_cnt),
      .y(y_c), .match(match_c), .match_cnt(match_cnt_c));

   typedef struct packed {
      logic [1:0] restart;  // 0 none, 1 reset, 2 load pat/msk
      logic [3:0] pat;
      logic [3:0] msk;
      logic       ov;
      logic       xb;
      logic [1:0] y;
      logic       m;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[23];

   function automatic vec_t mk(logic [1:0] r, logic [3:0] p, logic [3:0] k, logic ov,
                               logic xb, logic [1:0] ey, logic em, logic [7:0] ec);
      vec_t v;
      v.restart = r; v.pat = p; v.msk = k; v.ov = ov;
      v.xb = xb; v.y = ey; v.m = em; v.cnt = ec;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(logic b);
      en = 1'b1;
      x  = b;
      tick();
      en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic do_load(logic [3:0] p, logic [3:0] k);
      pat_in  = p;
      mask_in = k;
      pat_ld  = 1'b1;
      tick();
      pat_ld  = 1'b0;
   endtask

   initial begin
      // overlap, pattern 1011, stream 1011011
      vecs[0]  = mk(2'd1, 4'b1011, 4'b1111, 1'b1, 1'b1, 2'b01, 1'b0, 8'd0);
      vecs[1]  = mk(2'd0, 4'b1011, 4'b1111, 1'b1, 1'b0, 2'b01, 1'b0, 8'd0);
      vecs[2]  = mk(2'd0, 4'b1011, 4'b1111, 1'b1, 1'b1, 2'b01, 1'b0, 8'd0);
      vecs[3]  = mk(2'd0, 4'b1011, 4'b1111, 1'b1, 1'b1, 2'b11, 1'b1, 8'd1);
      vecs[4]  = mk(2'd0, 4'b1011, 4'b1111, 1'b1, 1'b0, 2'b10, 1'b0, 8'd1);
      vecs[5]  = mk(2'd0, 4'b1011, 4'b1111, 1'b1, 1'b1, 2'b10, 1'b0, 8'd1);
      vecs[6]  = mk(2'd0, 4'b1011, 4'b1111, 1'b1, 1'b1, 2'b11, 1'b1, 8'd2);
      // non-overlap, same stream
      vecs[7]  = mk(2'd1, 4'b1011, 4'b1111, 1'b0, 1'b1, 2'b01, 1'b0, 8'd0);
      vecs[8]  = mk(2'd0, 4'b1011, 4'b1111, 1'b0, 1'b0, 2'b01, 1'b0, 8'd0);
      vecs[9]  = mk(2'd0, 4'b1011, 4'b1111, 1'b0, 1'b1, 2'b01, 1'b0, 8'd0);
      vecs[10] = mk(2'd0, 4'b1011, 4'b1111, 1'b0, 1'b1, 2'b11, 1'b1, 8'd1);
      vecs[11] = mk(2'd0, 4'b1011, 4'b1111, 1'b0, 1'b0, 2'b01, 1'b0, 8'd1);
      vecs[12] = mk(2'd0, 4'b1011, 4'b1111, 1'b0, 1'b1, 2'b01, 1'b0, 8'd1);
      vecs[13] = mk(2'd0, 4'b1011, 4'b1111, 1'b0, 1'b1, 2'b01, 1'b0, 8'd1);
      // masked pattern 1xx1, stream 1111
      vecs[14] = mk(2'd2, 4'b1001, 4'b1001, 1'b1, 1'b1, 2'b01, 1'b0, 8'd1);
      vecs[15] = mk(2'd0, 4'b1001, 4'b1001, 1'b1, 1'b1, 2'b01, 1'b0, 8'd1);
      vecs[16] = mk(2'd0, 4'b1001, 4'b1001, 1'b1, 1'b1, 2'b01, 1'b0, 8'd1);
      vecs[17] = mk(2'd0, 4'b1001, 4'b1001, 1'b1, 1'b1, 2'b11, 1'b1, 8'd2);
      // reload, stream 01001
      vecs[18] = mk(2'd2, 4'b1001, 4'b1001, 1'b1, 1'b0, 2'b01, 1'b0, 8'd2);
      vecs[19] = mk(2'd0, 4'b1001, 4'b1001, 1'b1, 1'b1, 2'b01, 1'b0, 8'd2);
      vecs[20] = mk(2'd0, 4'b1001, 4'b1001, 1'b1, 1'b0, 2'b01, 1'b0, 8'd2);
      vecs[21] = mk(2'd0, 4'b1001, 4'b1001, 1'b1, 1'b0, 2'b10, 1'b0, 8'd2);
      vecs[22] = mk(2'd0, 4'b1001, 4'b1001, 1'b1, 1'b1, 2'b11, 1'b1, 8'd3);

      #2;
      do_reset();
      check("reset_y", 32'(y), 32'(2'b00));
      check("reset_match", 32'(match), 32'd0);

      foreach (vecs[i]) begin
         overlap = vecs[i].ov;
         if (vecs[i].restart == 2'd1) do_reset();
         if (vecs[i].restart == 2'd2) do_load(vecs[i].pat, vecs[i].msk);
         step(vecs[i].xb);
         check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].y));
         check($sformatf("vec%0d_match", i), 32'(match), 32'(vecs[i].m));
         check($sformatf("vec%0d_cnt", i), 32'(match_cnt), 32'(vecs[i].cnt));
      end

      // async reset mid-cycle while a match is showing
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_y", 32'(y), 32'(2'b00));
      check("async_rst_match", 32'(match), 32'd0);
      check("async_rst_cnt", 32'(match_cnt), 32'd0);
      check("async_rst_pattern", 32'(dut.pattern), 32'(4'b1011));
      check("async_rst_mask", 32'(dut.mask), 32'(4'b1111));
      en = 1'b1; x = 1'b1;
      tick();
      en = 1'b0;
      check("held_rst_y", 32'(y), 32'(2'b00));
      rst = 1'b1;
      tick();
      check("post_rst_match", 32'(match), 32'd0);
      check("post_rst_y", 32'(y), 32'(2'b00));
      step(1'b1);
      check("post_rst_fill_y", 32'(y), 32'(2'b01));

      // counter saturation on the 2-bit instance, mask all zeros
      do_reset();
      overlap = 1'b1;
      do_load(4'b0000, 4'b0000);
      for (int i = 0; i < 3; i++) step(1'b0);
      check("cnt_prefill_match", 32'(match_c), 32'd0);
      check("cnt_prefill_y", 32'(y_c), 32'(2'b01));
      for (int i = 0; i < 6; i++) begin
         step(i[0]);
         check($sformatf("cnt_sat_%0d", i), 32'(match_cnt_c), (i < 2) ? 32'(i + 1) : 32'd3);
         check($sformatf("cnt_sat_match_%0d", i), 32'(match_c), 32'd1);
      end
      check("cnt_wide", 32'(match_cnt), 32'd6);
      clr_cnt = 1'b1;
      step(1'b1);
      check("clr_with_match", 32'(match_cnt_c), 32'd1);
      tick();
      check("clr_alone", 32'(match_cnt_c), 32'd0);
      check("clr_alone_wide", 32'(match_cnt), 32'd0);
      clr_cnt = 1'b0;

      // load priority over en mid-fill
      do_reset();
      overlap = 1'b0;
      step(1'b1); step(1'b0); step(1'b1); step(1'b1);
      check("ld_pre_match_y", 32'(y), 32'(2'b11));
      tick();
      check("hit_to_idle_y", 32'(y), 32'(2'b00));
      check("hit_to_idle_match", 32'(match), 32'd0);
      step(1'b1); step(1'b0); step(1'b1);
      check("ld_fill3", 32'(dut.u_window.fill), 32'd3);
      pat_in = 4'b1011; mask_in = 4'b1111;
      pat_ld = 1'b1; en = 1'b1; x = 1'b1;
      tick();
      pat_ld = 1'b0; en = 1'b0;
      check("ld_y", 32'(y), 32'(2'b00));
      check("ld_match", 32'(match), 32'd0);
      check("ld_fill", 32'(dut.u_window.fill), 32'd0);
      check("ld_cnt", 32'(match_cnt), 32'd1);
      step(1'b0); step(1'b1); step(1'b1);
      check("ld_refill_y", 32'(y), 32'(2'b01));
      check("ld_refill_match", 32'(match), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
